shift_right_unit: RTL and testbench



---
 rtl/shift_right_unit.sv | 127 ++++++++++++
 tb/tb_shift_right_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/shift_right_unit.sv
// Purpose : iterative right shifter (logical / arithmetic), one bit position per clock.
// Latency : Start accepted at edge 0 -> Done pulses in cycle ShAmt+1; ShAmt=0 completes in cycle 1.
// Backpr. : no queueing; Start is ignored while Busy=1, and the caller stalls until Done.
//
// Ports
//   Clk      rising-edge clock
//   Reset    synchronous, active-high reset (beats Start in the same cycle)
//   Start    launch request, sampled only while idle
//   Arith    1 = sign-fill, 0 = zero-fill, sampled with Start
//   Operand  value to shift, sampled with Start
//   ShAmt    shift distance 0..WIDTH-1, sampled with Start
//   Busy     high from the cycle after an accepted Start through the Done cycle
//   Done     one-cycle completion pulse
//   Result   shifted value, held until the next completion
module shift_right_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Arith,
    input  logic [WIDTH-1:0] Operand,
    input  logic [SHW-1:0]   ShAmt,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    // The counter must be exactly wide enough to hold WIDTH-1.
    if (SHW != $clog2(WIDTH)) begin : g_bad_shw
        $error("shift_right_unit: SHW must equal log2(WIDTH)");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] work_d;
    logic [SHW-1:0]   cnt_q;
    logic             fill_mode_q;
    logic             sign_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             fill_bit;
    logic             last_step;

    // One-position shift of the working register. The fill bit comes from the
    // latched sign, so later changes on Operand cannot leak into the shift.
    always_comb begin
        fill_bit  = fill_mode_q & sign_q;
        work_d    = {fill_bit, work_q[WIDTH-1:1]};
        last_step = (cnt_q == SHW'(1));
    end

    // Single-process FSM: Busy and Done are registered alongside the state so
    // they always equal (state != IDLE) and (state == DONE) respectively.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            fill_mode_q <= 1'b0;
            sign_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (Start) begin
                        work_q      <= Operand;
                        cnt_q       <= ShAmt;
                        fill_mode_q <= Arith;
                        sign_q      <= Operand[WIDTH-1];
                        busy_q      <= 1'b1;
                        if (ShAmt == '0) begin
                            // Nothing to shift: publish the operand directly.
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            result_q <= Operand;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - SHW'(1);
                    // Exiting at cnt==1 means the counter never wraps, and the
                    // final shifted value goes straight into Result on this edge.
                    if (last_step) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        result_q <= work_d;
                    end
                end

                DONE: begin
                    // Exactly one cycle; any Start seen here is dropped.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_shift_right_unit.sv
module tb_shift_right_unit;
    localparam int W = 32;
    localparam int S = 5;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic         Arith = 1'b0;
    logic [W-1:0] Operand = '0;
    logic [S-1:0] ShAmt = '0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    shift_right_unit #(.WIDTH(W), .SHW(S)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Arith(Arith),
        .Operand(Operand), .ShAmt(ShAmt),
        .Busy(Busy), .Done(Done), .Result(Result)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] model(input logic [W-1:0] op, input int amt, input logic ar);
        if (ar) return $unsigned($signed(op) >>> amt);
        return op >> amt;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every Done must match the oldest expectation in
    // both value and cycle; a Done with nothing pending is itself a failure.
    always @(negedge Clk) begin
        if (!Reset && Done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", Result, e.res);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive one request for one cycle; the following edge is the accepting
    // edge. Inputs are scrambled afterwards so only latched copies matter.
    task automatic launch(input logic [W-1:0] op, input int amt, input logic ar, input bit expect_it);
        exp_t e;
        @(posedge Clk); #1;
        Start = 1'b1; Operand = op; ShAmt = S'(amt); Arith = ar;
        if (expect_it) begin
            e.res = model(op, amt, ar);
            e.cyc = cyc + 1 + amt;
            sb.push_back(e);
        end
        @(posedge Clk); #1;
        Start = 1'b0; Operand = $urandom; ShAmt = S'($urandom); Arith = 1'($urandom);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (!Busy) break;
            n++;
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && (sb.size() != 0 || Busy); i++) @(negedge Clk);
        check(tag, 32'((sb.size() == 0) && !Busy), 32'd1);
    endtask

    initial begin
        int n;
        logic [W-1:0] op;
        int amt;
        logic ar;

        // Reset and idle state
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_result", Result, 32'h0);

        // Logical shift with Busy duration
        launch(32'hF000_0000, 4, 1'b0, 1'b1);
        count_busy(n);
        check("busy_len_4", 32'(n), 32'd5);
        drain("drain_lsr4");

        // Arithmetic full-width shift; Result must hold during SHIFT
        launch(32'h8000_0000, 31, 1'b1, 1'b1);
        repeat (10) @(negedge Clk);
        check("hold_in_shift", Result, 32'h0F00_0000);
        check("busy_in_shift", 32'(Busy), 32'd1);
        drain("drain_asr31");
        launch(32'h8000_0000, 31, 1'b0, 1'b1);
        drain("drain_lsr31");

        // Zero shift
        launch(32'hDEAD_BEEF, 0, 1'b1, 1'b1);
        count_busy(n);
        check("busy_len_0", 32'(n), 32'd1);
        drain("drain_zero");

        // Start while busy is ignored
        launch(32'h0000_1000, 8, 1'b0, 1'b1);
        @(posedge Clk); @(posedge Clk); #1;
        Start = 1'b1; Operand = 32'hFFFF_FFFF; ShAmt = S'(1); Arith = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        drain("drain_ignored");
        repeat (10) @(negedge Clk);
        check("ignored_result_held", Result, 32'h0000_0010);

        // Back-to-back with Start held high: three accepts at interval 4
        @(posedge Clk); #1;
        Start = 1'b1; Operand = 32'h0000_0100; ShAmt = S'(2); Arith = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.res = 32'h0000_0040;
            e.cyc = cyc + 1 + 4 * k + 2;
            sb.push_back(e);
        end
        repeat (9) @(posedge Clk);
        #1 Start = 1'b0;
        drain("drain_b2b");
        repeat (6) @(negedge Clk);

        // Mixed operations against the reference model
        for (int k = 0; k < 6; k++) begin
            op  = $urandom;
            amt = $urandom_range(0, 31);
            ar  = 1'($urandom);
            if (k == 0) begin op = 32'h7FFF_FFFF; ar = 1'b1; end
            launch(op, amt, ar, 1'b1);
            drain("drain_mix");
        end

        // Reset mid-operation: abort with no Done and Result cleared
        launch(32'hC000_0000, 20, 1'b1, 1'b0);
        repeat (5) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        @(negedge Clk);
        check("abort_result", Result, 32'h0);
        check("abort_busy", 32'(Busy), 32'd0);
        repeat (25) @(negedge Clk);
        check("abort_no_done_result", Result, 32'h0);

        // Reset wins over Start in the same cycle
        @(posedge Clk); #1;
        Reset = 1'b1; Start = 1'b1; Operand = 32'h1234_5678; ShAmt = S'(0);
        @(posedge Clk); #1;
        Reset = 1'b0; Start = 1'b0;
        @(negedge Clk);
        check("reset_priority_busy", 32'(Busy), 32'd0);
        check("reset_priority_result", Result, 32'h0);
        repeat (3) @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
